// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the program-counter sequencer
package pc_pkg;

    localparam int INSTR_BYTES = 4;

    // Legal next-PC selects; encodings 6 and 7 are reserved/illegal.
    typedef enum logic [2:0] {
        PC_PLUS4  = 3'd0,
        PC_JALR   = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JAL    = 3'd3,
        PC_MTVEC  = 3'd4,
        PC_MEPC   = 3'd5
    } pc_src_t;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with saturating occupancy count
//
// Ports:
//   clk, pc_reset   clock, synchronous active-high reset
//   push, pop       stack operations (already qualified by the caller)
//   push_data       return address to store
//   top             top-of-stack entry, 0 when empty
//   valid           stack holds at least one entry
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            pc_reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            valid
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;      // next slot to write
    logic [PW-1:0]   top_idx;  // most recently written slot
    logic [CW-1:0]   count;

    // RAS_DEPTH is a power of two, so the pointer wraps naturally.
    assign top_idx = ptr - PW'(1);
    assign valid   = (count != '0);
    assign top     = valid ? mem[top_idx] : '0;

    always_ff @(posedge clk) begin
        if (pc_reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && (!pop || count == '0)) begin
            // Plain push (or push+pop on empty): when full the oldest entry
            // is overwritten because the write slot wraps onto it.
            mem[ptr] <= push_data;
            ptr      <= ptr + PW'(1);
            if (count != CW'(RAS_DEPTH))
                count <= count + CW'(1);
        end else if (push && pop) begin
            // Return immediately followed by a call: replace the top in place.
            mem[top_idx] <= push_data;
        end else if (pop && count != '0) begin
            ptr   <= top_idx;
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, next-PC select, misalign trap redirect and RAS
//
// Ports:
//   clk, pc_reset            clock, synchronous active-high reset
//   pc_write, pc_source      advance enable and next-PC select (6/7 illegal)
//   jalr, branch, jal        control-transfer targets
//   mtvec, mepc              trap vector (low 2 bits ignored) and trap return
//   ras_push, ras_pop        call/return bookkeeping for the current transfer
//   pc_out, pc_plus4         registered PC and its wrapping +4
//   misalign_fault, fault_addr  fault pulse and held offending target
//   illegal_src              pulse for a reserved select with pc_write
//   ras_top, ras_valid       return-address stack view
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4,
    parameter int              C_EXT     = 0
) (
    input  logic            clk,
    input  logic            pc_reset,
    input  logic            pc_write,
    input  logic [2:0]      pc_source,
    input  logic [XLEN-1:0] jalr,
    input  logic [XLEN-1:0] branch,
    input  logic [XLEN-1:0] jal,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign_fault,
    output logic [XLEN-1:0] fault_addr,
    output logic            illegal_src,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_valid
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] fault_addr_d;
    logic            fault_d;
    logic            illegal_d;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] mtvec_base;
    logic            check_align;
    logic            src_legal;
    logic            misaligned;
    logic            ras_push_en;
    logic            ras_pop_en;

    assign pc_plus4   = pc_out + XLEN'(INSTR_BYTES);
    assign mtvec_base = mtvec & ~XLEN'(3);

    always_comb begin
        tgt         = pc_plus4;
        check_align = 1'b0;
        src_legal   = 1'b1;
        case (pc_source)
            PC_PLUS4:  tgt = pc_plus4;
            PC_JALR:   begin tgt = jalr;   check_align = 1'b1; end
            PC_BRANCH: begin tgt = branch; check_align = 1'b1; end
            PC_JAL:    begin tgt = jal;    check_align = 1'b1; end
            PC_MTVEC:  tgt = mtvec_base;
            PC_MEPC:   begin tgt = mepc;   check_align = 1'b1; end
            default:   src_legal = 1'b0;
        endcase
    end

    // Compressed-ISA builds only need halfword alignment.
    assign misaligned = check_align &&
                        ((C_EXT != 0) ? tgt[0] : (tgt[1:0] != 2'b00));

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_out;
        fault_d      = 1'b0;
        illegal_d    = 1'b0;
        fault_addr_d = fault_addr;
        ras_push_en  = 1'b0;
        ras_pop_en   = 1'b0;
        case (state_q)
            RUN: begin
                if (pc_write) begin
                    if (!src_legal) begin
                        illegal_d = 1'b1;
                    end else if (misaligned) begin
                        fault_d      = 1'b1;
                        fault_addr_d = tgt;
                        state_d      = REDIRECT;
                    end else begin
                        pc_d        = tgt;
                        ras_push_en = ras_push;
                        ras_pop_en  = ras_pop;
                    end
                end
            end
            REDIRECT: begin
                // Trap entry is forced; the control FSM has no say here.
                pc_d    = mtvec_base;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pc_reset) begin
            state_q        <= RUN;
            pc_out         <= RESET_VEC;
            misalign_fault <= 1'b0;
            illegal_src    <= 1'b0;
            fault_addr     <= '0;
        end else begin
            state_q        <= state_d;
            pc_out         <= pc_d;
            misalign_fault <= fault_d;
            illegal_src    <= illegal_d;
            fault_addr     <= fault_addr_d;
        end
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .pc_reset  (pc_reset),
        .push      (ras_push_en),
        .pop       (ras_pop_en),
        .push_data (pc_plus4),
        .top       (ras_top),
        .valid     (ras_valid)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk;
    logic        pc_reset, pc_write;
    logic [2:0]  pc_source;
    logic [31:0] jalr, branch, jal, mtvec, mepc;
    logic        ras_push, ras_pop;
    logic [31:0] pc_out, pc_plus4, fault_addr, ras_top;
    logic        misalign_fault, illegal_src, ras_valid;

    logic        c1_reset, c1_write;
    logic [2:0]  c1_source;
    logic [31:0] c1_jalr;
    logic [31:0] c1_pc_out, c1_pc_plus4, c1_fault_addr, c1_ras_top;
    logic        c1_misalign_fault, c1_illegal_src, c1_ras_valid;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.XLEN(32), .RESET_VEC(32'h0), .RAS_DEPTH(4), .C_EXT(0)) dut (
        .clk(clk), .pc_reset(pc_reset), .pc_write(pc_write), .pc_source(pc_source),
        .jalr(jalr), .branch(branch), .jal(jal), .mtvec(mtvec), .mepc(mepc),
        .ras_push(ras_push), .ras_pop(ras_pop), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .misalign_fault(misalign_fault), .fault_addr(fault_addr),
        .illegal_src(illegal_src), .ras_top(ras_top), .ras_valid(ras_valid)
    );

    pc_sequencer #(.XLEN(32), .RESET_VEC(32'h0), .RAS_DEPTH(4), .C_EXT(1)) dut_c (
        .clk(clk), .pc_reset(c1_reset), .pc_write(c1_write), .pc_source(c1_source),
        .jalr(c1_jalr), .branch(branch), .jal(jal), .mtvec(mtvec), .mepc(mepc),
        .ras_push(1'b0), .ras_pop(1'b0), .pc_out(c1_pc_out), .pc_plus4(c1_pc_plus4),
        .misalign_fault(c1_misalign_fault), .fault_addr(c1_fault_addr),
        .illegal_src(c1_illegal_src), .ras_top(c1_ras_top), .ras_valid(c1_ras_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [2:0] src, input logic [31:0] j, input logic push, input logic pop);
        pc_write = 1'b1; pc_source = src; jal = j; ras_push = push; ras_pop = pop;
        step();
        ras_push = 1'b0; ras_pop = 1'b0;
    endtask

    initial begin
        pc_reset = 1'b1; pc_write = 1'b0; pc_source = 3'd0;
        jalr = 32'h0; branch = 32'h0; jal = 32'h0; mtvec = 32'h8001; mepc = 32'h0;
        ras_push = 1'b0; ras_pop = 1'b0;
        c1_reset = 1'b1; c1_write = 1'b0; c1_source = 3'd0; c1_jalr = 32'h0;
        step();
        chk("reset_pc", pc_out, 32'h0);
        chk("reset_fault", {31'd0, misalign_fault}, 32'h0);
        chk("reset_illegal", {31'd0, illegal_src}, 32'h0);
        chk("reset_fault_addr", fault_addr, 32'h0);
        chk("reset_ras_valid", {31'd0, ras_valid}, 32'h0);
        chk("reset_ras_top", ras_top, 32'h0);

        // Sequential fetch, then reset mid-stream with pc_write still high.
        pc_reset = 1'b0; c1_reset = 1'b0;
        xfer(3'd0, 32'h0, 1'b0, 1'b0); chk("seq_4", pc_out, 32'h4);
        xfer(3'd0, 32'h0, 1'b0, 1'b0); chk("seq_8", pc_out, 32'h8);
        xfer(3'd0, 32'h0, 1'b0, 1'b0); chk("seq_c", pc_out, 32'hC);
        chk("plus4_c", pc_plus4, 32'h10);
        pc_reset = 1'b1; step(); pc_reset = 1'b0;
        chk("mid_reset_pc", pc_out, 32'h0);

        // Misaligned jalr with 4-byte alignment, then forced redirect.
        xfer(3'd3, 32'h100, 1'b0, 1'b0); chk("jal_100", pc_out, 32'h100);
        pc_source = 3'd1; jalr = 32'h202; ras_push = 1'b1; step(); ras_push = 1'b0;
        chk("mis_pulse", {31'd0, misalign_fault}, 32'h1);
        chk("mis_addr", fault_addr, 32'h202);
        chk("mis_pc_hold", pc_out, 32'h100);
        chk("mis_ras_untouched", {31'd0, ras_valid}, 32'h0);
        pc_write = 1'b0; step();
        chk("redirect_pc", pc_out, 32'h8000);
        chk("mis_pulse_low", {31'd0, misalign_fault}, 32'h0);
        chk("mis_addr_held", fault_addr, 32'h202);
        step();
        chk("idle_hold", pc_out, 32'h8000);

        // Aligned alternate sources.
        mepc = 32'h500; xfer(3'd5, 32'h0, 1'b0, 1'b0); chk("mepc", pc_out, 32'h500);
        branch = 32'h600; xfer(3'd2, 32'h0, 1'b0, 1'b0); chk("branch", pc_out, 32'h600);
        xfer(3'd4, 32'h0, 1'b0, 1'b0); chk("mtvec_src", pc_out, 32'h8000);

        // Illegal select.
        xfer(3'd3, 32'h40, 1'b0, 1'b0); chk("jal_40", pc_out, 32'h40);
        xfer(3'd6, 32'h0, 1'b0, 1'b0);
        chk("illegal_pulse", {31'd0, illegal_src}, 32'h1);
        chk("illegal_pc_hold", pc_out, 32'h40);
        pc_write = 1'b0; step();
        chk("illegal_pulse_low", {31'd0, illegal_src}, 32'h0);
        xfer(3'd0, 32'h0, 1'b0, 1'b0); chk("illegal_still_run", pc_out, 32'h44);

        // RAS overflow and underflow.
        xfer(3'd3, 32'h10, 1'b0, 1'b0);
        xfer(3'd3, 32'h20, 1'b1, 1'b0);
        xfer(3'd3, 32'h30, 1'b1, 1'b0);
        xfer(3'd3, 32'h40, 1'b1, 1'b0);
        xfer(3'd3, 32'h50, 1'b1, 1'b0);
        xfer(3'd3, 32'h60, 1'b1, 1'b0);
        chk("ras_top_54", ras_top, 32'h54);
        chk("ras_valid_full", {31'd0, ras_valid}, 32'h1);
        xfer(3'd0, 32'h0, 1'b0, 1'b1); chk("ras_pop_44", ras_top, 32'h44);
        xfer(3'd0, 32'h0, 1'b0, 1'b1); chk("ras_pop_34", ras_top, 32'h34);
        xfer(3'd0, 32'h0, 1'b0, 1'b1); chk("ras_pop_24", ras_top, 32'h24);
        xfer(3'd0, 32'h0, 1'b0, 1'b1);
        chk("ras_empty_valid", {31'd0, ras_valid}, 32'h0);
        chk("ras_empty_top", ras_top, 32'h0);
        xfer(3'd0, 32'h0, 1'b0, 1'b1);
        chk("ras_extra_pop", {31'd0, ras_valid}, 32'h0);

        // Wrap of PC arithmetic.
        xfer(3'd3, 32'hFFFF_FFFC, 1'b0, 1'b0);
        chk("wrap_plus4", pc_plus4, 32'h0);
        xfer(3'd0, 32'h0, 1'b0, 1'b0); chk("wrap_pc", pc_out, 32'h0);

        // push+pop with one entry replaces the top; count stays 1.
        xfer(3'd3, 32'h200, 1'b1, 1'b0); chk("pp_first", ras_top, 32'h4);
        xfer(3'd3, 32'h300, 1'b1, 1'b1);
        chk("pp_replace_top", ras_top, 32'h204);
        chk("pp_valid", {31'd0, ras_valid}, 32'h1);
        xfer(3'd0, 32'h0, 1'b0, 1'b1);
        chk("pp_count_one", {31'd0, ras_valid}, 32'h0);
        chk("pp_pc", pc_out, 32'h304);
        xfer(3'd3, 32'h400, 1'b1, 1'b1);
        chk("pp_empty_push", ras_top, 32'h308);

        // Reset during REDIRECT wins.
        pc_source = 3'd1; jalr = 32'h6; step();
        chk("mis2_pulse", {31'd0, misalign_fault}, 32'h1);
        pc_reset = 1'b1; step(); pc_reset = 1'b0;
        chk("rst_redirect_pc", pc_out, 32'h0);
        chk("rst_redirect_pulse", {31'd0, misalign_fault}, 32'h0);
        chk("rst_redirect_addr", fault_addr, 32'h0);
        chk("rst_redirect_ras", {31'd0, ras_valid}, 32'h0);
        xfer(3'd0, 32'h0, 1'b0, 1'b0); chk("rst_redirect_run", pc_out, 32'h4);
        pc_write = 1'b0;

        // Compressed-alignment build.
        c1_write = 1'b1; c1_source = 3'd1; c1_jalr = 32'h202; step();
        chk("c_ext_aligned_pc", c1_pc_out, 32'h202);
        chk("c_ext_no_fault", {31'd0, c1_misalign_fault}, 32'h0);
        c1_jalr = 32'h203; step();
        chk("c_ext_fault", {31'd0, c1_misalign_fault}, 32'h1);
        chk("c_ext_fault_addr", c1_fault_addr, 32'h203);
        chk("c_ext_pc_hold", c1_pc_out, 32'h202);
        step();
        chk("c_ext_redirect", c1_pc_out, 32'h8000);
        c1_write = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program-counter unit for the multicycle RISC-V core. It owns the PC register, computes PC+4 internally and selects the next PC from six sources. It adds three things the previous PC block lacked: a misaligned-target trap redirect FSM, an illegal-select guard, and a small return-address stack (RAS) for call/return bookkeeping. It sits between the control FSM (pc_write, pc_source, ras_push/ras_pop) and the fetch/memory interface (pc_out).

Parameters:
XLEN, 32, PC and target width in bits
RESET_VEC, 32'h0000_0000, PC value loaded on reset (XLEN bits)
RAS_DEPTH, 4, RAS entries; power of two, ≥2
C_EXT, 0, 1 = 2-byte target alignment allowed; 0 = 4-byte alignment required

Ports:
clk  in  1  core clock
pc_reset  in  1  synchronous active-high reset
pc_write  in  1  advance enable; PC updates only when high (except REDIRECT)
pc_source  in  3  next-PC select: 0 PC+4, 1 jalr, 2 branch, 3 jal, 4 mtvec, 5 mepc, 6–7 illegal
jalr  in  XLEN  jalr target
branch  in  XLEN  branch target
jal  in  XLEN  jal target
mtvec  in  XLEN  trap vector; low 2 bits masked to 0 on use
mepc  in  XLEN  trap return address
ras_push  in  1  current transfer is a call; push PC+4
ras_pop  in  1  current transfer is a return; pop top
pc_out  out  XLEN  current PC (registered)
pc_plus4  out  XLEN  pc_out+4, modulo 2^XLEN (combinational)
misalign_fault  out  1  one-cycle pulse: selected target misaligned
fault_addr  out  XLEN  offending target; held until the next fault
illegal_src  out  1  one-cycle pulse: pc_source 6/7 with pc_write
ras_top  out  XLEN  top RAS entry; 0 when empty
ras_valid  out  1  RAS non-empty

Behaviour:
- Reset (synchronous, wins over everything, including mid-REDIRECT): pc_out=RESET_VEC, state=RUN, misalign_fault=0, illegal_src=0, fault_addr=0, RAS count=0, RAS pointer=0, ras_valid=0.
- FSM states: RUN, REDIRECT.
- RUN, pc_write=0: hold PC. No fault evaluation, no RAS operation, pulses low.
- RUN, pc_write=1, source 0–5: tgt = selected value (source 4 uses mtvec&~3).
  - Misaligned means tgt[1:0]!=0 when C_EXT=0, or tgt[0]!=0 when C_EXT=1. Checked only for sources 1, 2, 3 and 5.
  - Aligned: pc_out<=tgt next cycle (latency 1).
  - Misaligned: PC holds; misalign_fault=1 next cycle; fault_addr<=tgt; RAS untouched; go to REDIRECT.
- RUN, pc_write=1, source 6/7: PC holds; illegal_src=1 next cycle; RAS untouched; stay RUN.
- REDIRECT: unconditionally pc_out<=mtvec&~3 at the next edge, ignoring pc_write, pc_source and RAS inputs; return to RUN. Total: fault cycle N, pulse visible N+1, mtvec loaded at edge N+2.
- RAS updates only on an accepted aligned transfer in RUN.
  - Push: stores pc_plus4 of the current PC. When full, overwrites the oldest entry (circular); count saturates at RAS_DEPTH.
  - Pop: decrements. On empty it is ignored; no error.
  - push+pop together: replace the top with pc_plus4; count unchanged. If empty, acts as push.
- Arithmetic: all additions wrap modulo 2^XLEN (pc 32'hFFFF_FFFC → pc_plus4 0). No sign extension inside the block.

Decomposition:
- pc_pkg:
  - pc_src_t enum (PC_PLUS4, PC_JALR, PC_BRANCH, PC_JAL, PC_MTVEC, PC_MEPC)
  - pc_state_t enum (RUN, REDIRECT)
  - constant INSTR_BYTES=4
- Sub-module pc_ras (params XLEN, RAS_DEPTH; ports clk, pc_reset, push, pop, push_data, top, valid) holds the circular stack and count.
- Top level holds the select mux, alignment check, FSM and PC register.

Test Plan:
- Reset then pc_write=1, source 0 for 3 cycles → pc_out 0, 4, 8, C; pc_reset asserted mid-stream → pc_out=0 next cycle.
- pc_out=0x100, source 1, jalr=0x202, C_EXT=0 → misalign_fault pulse, fault_addr=0x202, pc_out holds 0x100, then becomes mtvec&~3 (mtvec=0x8001 → 0x8000) regardless of pc_write.
- Same with C_EXT=1 and jalr=0x202 → no fault, pc_out=0x202; jalr=0x203 → fault.
- source 6 with pc_write=1 at pc_out=0x40 → illegal_src one-cycle pulse, pc_out stays 0x40, FSM in RUN.
- RAS_DEPTH=4: 5 pushes (jal) from PCs 0x10, 0x20, 0x30, 0x40, 0x50 → ras_top=0x54, then 4 pops yield tops 0x44, 0x34, 0x24, then ras_valid=0 (0x14 overwritten); a further pop is ignored.
- pc_out=0xFFFF_FFFC, source 0 → pc_out=0; push+pop together with 1 entry → count stays 1, ras_top=new pc_plus4.
